// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer RAM between a buffered
// fire-and-forget pixel writer and a latency-sensitive display read port.
module fb_port_arbiter #(
  parameter int H_RES        = 640,
  parameter int PIX_PER_WORD = 8,
  parameter int ADDR_W       = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        wr_addr_x,
  input  logic [9:0]        wr_addr_y,
  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  input  logic              wr_frame_done,
  input  logic              rd_req,
  input  logic [9:0]        rd_addr_x,
  input  logic [9:0]        rd_addr_y,
  output logic              rd_grant,
  output logic [31:0]       rd_data,
  output logic              rd_data_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              fifo_overflow,
  output logic              frame_ready
);

  localparam int WORDS_PER_LINE = H_RES / PIX_PER_WORD;
  localparam int PIX_SHIFT      = $clog2(PIX_PER_WORD);
  localparam int PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W          = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ST_RECEIVING, ST_DRAINING, ST_READY} frame_state_t;

  function automatic logic [ADDR_W-1:0] pix_to_addr(input logic [9:0] x, input logic [9:0] y);
    logic [31:0] lin;
    lin = 32'(y) * 32'(WORDS_PER_LINE) + 32'(x >> PIX_SHIFT);
    return lin[ADDR_W-1:0];
  endfunction

  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [31:0]       fifo_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  frame_state_t      frame_state_q, frame_state_d;

  logic fifo_full, fifo_empty, force_wr, grant, pop, push;

  always_comb begin
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    force_wr   = fifo_full && (starve_q == STV_W'(STARVE_LIMIT));
    grant      = 1'b0;
    pop        = 1'b0;
    // No decisions while reset is asserted so rd_grant also reads 0.
    if (reset) begin
      if (force_wr)         pop   = 1'b1;
      else if (rd_req)      grant = 1'b1;
      else if (!fifo_empty) pop   = 1'b1;
    end
    push = reset && wr_valid && (!fifo_full || pop);

    wr_ptr_d = push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    if (pop || !fifo_full) starve_d = '0;
    else if (grant)        starve_d = STV_W'(starve_q + 1'b1);
    else                   starve_d = starve_q;

    mem_en_d    = grant || pop;
    mem_we_d    = pop;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (pop) begin
      mem_addr_d  = fifo_addr_mem[rd_ptr_q];
      mem_wdata_d = fifo_data_mem[rd_ptr_q];
    end else if (grant) begin
      mem_addr_d  = pix_to_addr(rd_addr_x, rd_addr_y);
    end

    // RAM returns data the cycle after a registered read strobe.
    rd_valid_d   = mem_en_q && !mem_we_q;
    overflow_d   = overflow_q || (reset && wr_valid && !push);
    frame_done_d = wr_frame_done;

    frame_state_d = frame_state_q;
    unique case (frame_state_q)
      ST_RECEIVING: if (wr_frame_done && !frame_done_q) frame_state_d = ST_DRAINING;
      ST_DRAINING:  if (fifo_empty && !(mem_en_q && mem_we_q) && !wr_valid)
                      frame_state_d = ST_READY;
      ST_READY:     if (wr_valid) frame_state_d = ST_RECEIVING;
      default:      frame_state_d = ST_RECEIVING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= pix_to_addr(wr_addr_x, wr_addr_y);
      fifo_data_mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      starve_q      <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_valid_q    <= 1'b0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_state_q <= ST_RECEIVING;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      starve_q      <= starve_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_valid_q    <= rd_valid_d;
      overflow_q    <= overflow_d;
      frame_done_q  <= frame_done_d;
      frame_state_q <= frame_state_d;
    end
  end

  assign rd_grant      = grant;
  assign rd_data_valid = rd_valid_q;
  assign rd_data       = rd_valid_q ? mem_rdata : 32'd0;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign fifo_overflow = overflow_q;
  assign frame_ready   = (frame_state_q == ST_READY);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: vector table, hand-written corner sequences and
// random traffic, all checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_fb_port_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int F_RECV = 0, F_DRAIN = 1, F_READY = 2;

  logic        clk = 1'b0, reset = 1'b0;
  logic [9:0]  wr_addr_x = '0, wr_addr_y = '0, rd_addr_x = '0, rd_addr_y = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0, wr_frame_done = 1'b0, rd_req = 1'b0;
  logic        rd_grant, rd_data_valid, mem_en, mem_we, fifo_overflow, frame_ready;
  logic [31:0] rd_data, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  always #5 clk = ~clk;

  fb_port_arbiter dut (
    .clk(clk), .reset(reset), .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_frame_done(wr_frame_done),
    .rd_req(rd_req), .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y),
    .rd_grant(rd_grant), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_overflow(fifo_overflow), .frame_ready(frame_ready)
  );

  // Single-port RAM with one-cycle read latency.
  logic [31:0] ram [0:65535];
  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = '0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  typedef struct packed {logic [15:0] a; logic [31:0] d;} ent_t;
  ent_t        q[$];
  logic [31:0] img [0:65535];
  int          starve, fs;
  bit          e_en, e_we, rv1, rv2, ovf, done_prev, last_grant;
  logic [15:0] e_addr;
  logic [31:0] e_wdata, rd1, rd2;
  int          errors = 0, checks = 0;

  function automatic logic [15:0] addr_of(input logic [9:0] x, input logic [9:0] y);
    logic [31:0] lin;
    lin = 32'(y) * 32'd80 + 32'(x) / 32'd8;
    return lin[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    starve = 0; fs = F_RECV;
    e_en = 0; e_we = 0; rv1 = 0; rv2 = 0; ovf = 0; done_prev = 0; last_grant = 0;
    e_addr = '0; e_wdata = '0; rd1 = '0; rd2 = '0;
  endtask

  // Check this cycle's outputs, then advance the model across the next edge.
  task automatic step();
    int   sz;
    bit   full, frc, g, p;
    ent_t e;
    sz   = q.size();
    full = (sz == DEPTH);
    frc  = full && (starve == LIMIT);
    g    = rd_req && !frc;
    p    = frc || (!rd_req && sz > 0);
    chk("rd_grant", rd_grant, g);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (e_en && e_we) chk("mem_wdata", mem_wdata, e_wdata);
    chk("rd_data_valid", rd_data_valid, rv2);
    if (rv2) chk("rd_data", rd_data, rd2);
    chk("fifo_overflow", fifo_overflow, ovf);
    chk("frame_ready", frame_ready, fs == F_READY);
    case (fs)
      F_RECV:  if (wr_frame_done && !done_prev) fs = F_DRAIN;
      F_DRAIN: if (sz == 0 && !(e_en && e_we) && !wr_valid) fs = F_READY;
      default: if (wr_valid) fs = F_RECV;
    endcase
    done_prev = wr_frame_done;
    rv2 = rv1; rd2 = rd1; rv1 = g;
    e_en = g || p; e_we = p;
    if (p) begin
      e = q.pop_front();
      img[e.a] = e.d; e_addr = e.a; e_wdata = e.d;
    end else if (g) begin
      e_addr = addr_of(rd_addr_x, rd_addr_y);
      rd1 = img[e_addr];
    end
    if (wr_valid && (sz < DEPTH || p)) begin
      e.a = addr_of(wr_addr_x, wr_addr_y); e.d = wr_data;
      q.push_back(e);
    end else if (wr_valid) ovf = 1;
    if (p || !full) starve = 0;
    else if (g)     starve++;
    last_grant = g;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0; rd_req = 0; wr_valid = 0; wr_frame_done = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    reset = 1;
  endtask

  typedef struct {bit is_rd; logic [9:0] x; logic [9:0] y; logic [31:0] data; logic [15:0] exp_addr;} vec_t;
  vec_t vecs[10];

  initial begin
    bit gr[30];
    int first0, idx, cyc, bad;
    vecs[0] = '{0, 10'd16,   10'd2,    32'hDEADBEEF, 16'd162};
    vecs[1] = '{0, 10'd632,  10'd479,  32'hCAFEF00D, 16'd38399};
    vecs[2] = '{0, 10'd0,    10'd0,    32'h11111111, 16'd0};
    vecs[3] = '{0, 10'd1023, 10'd1023, 32'hA5A5A5A5, 16'd16431};
    vecs[4] = '{0, 10'd63,   10'd1,    32'h12345678, 16'd87};
    vecs[5] = '{1, 10'd632,  10'd479,  32'hCAFEF00D, 16'd38399};
    vecs[6] = '{1, 10'd16,   10'd2,    32'hDEADBEEF, 16'd162};
    vecs[7] = '{1, 10'd7,    10'd0,    32'h11111111, 16'd0};
    vecs[8] = '{1, 10'd1023, 10'd1023, 32'hA5A5A5A5, 16'd16431};
    vecs[9] = '{1, 10'd8,    10'd1,    32'h00000000, 16'd81};
    for (int a = 0; a < 65536; a++) img[a] = '0;
    model_reset();

    #1;
    chk("rst_mem_en", mem_en, 0);        chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);    chk("rst_rd_valid", rd_data_valid, 0);
    chk("rst_overflow", fifo_overflow, 0); chk("rst_frame_ready", frame_ready, 0);
    chk("rst_rd_grant", rd_grant, 0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_rd) begin
        rd_req = 1; rd_addr_x = vecs[i].x; rd_addr_y = vecs[i].y; #1;
        chk("tbl_rd_grant", rd_grant, 1);
        tick(); rd_req = 0;
        chk("tbl_rd_en", mem_en, 1); chk("tbl_rd_we", mem_we, 0);
        chk("tbl_rd_addr", mem_addr, vecs[i].exp_addr);
        tick();
        chk("tbl_rd_valid", rd_data_valid, 1); chk("tbl_rd_data", rd_data, vecs[i].data);
      end else begin
        wr_valid = 1; wr_addr_x = vecs[i].x; wr_addr_y = vecs[i].y; wr_data = vecs[i].data;
        tick(); wr_valid = 0; tick();
        chk("tbl_wr_en", mem_en, 1); chk("tbl_wr_we", mem_we, 1);
        chk("tbl_wr_addr", mem_addr, vecs[i].exp_addr); chk("tbl_wr_data", mem_wdata, vecs[i].data);
      end
      tick(); tick();
      $display("vec %0d %s x=%0d y=%0d addr=%0d data=%h", i, vecs[i].is_rd ? "RD" : "WR",
               vecs[i].x, vecs[i].y, vecs[i].exp_addr, vecs[i].data);
    end

    // Contention: continuous reads while four writes fill the FIFO.
    do_reset();
    rd_req = 1; rd_addr_x = 10'd100; rd_addr_y = 10'd10; first0 = -1;
    for (int i = 0; i < 30; i++) begin
      wr_valid = (i < 4); wr_addr_x = 10'(i * 8); wr_addr_y = 10'd300; wr_data = 32'hC0DE0000 + i;
      #1; gr[i] = rd_grant;
      tick();
    end
    wr_valid = 0; rd_req = 0;
    for (int i = 0; i < 30; i++) if (!gr[i] && first0 < 0) first0 = i;
    chk("contention_first_deny", first0, 12);
    chk("contention_resume", gr[13], 1);
    repeat (6) tick();
    for (int i = 0; i < 4; i++) chk("contention_landed", ram[24000 + i], 32'hC0DE0000 + i);
    $display("contention: first denied cycle %0d", first0);

    // Overflow: fifth pulse under continuous reads is dropped.
    do_reset();
    rd_req = 1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr_x = 10'(i * 8); wr_addr_y = 10'd400; wr_data = $urandom; tick();
    end
    wr_valid = 0; tick();
    chk("ovf_set", fifo_overflow, 1);
    rd_req = 0; repeat (10) tick();
    chk("ovf_sticky", fifo_overflow, 1);
    do_reset();
    chk("ovf_cleared", fifo_overflow, 0);
    $display("overflow: sticky flag exercised");

    // Async reset with a read in flight and a non-empty FIFO.
    rd_req = 1; rd_addr_x = 10'd40; rd_addr_y = 10'd5;
    wr_valid = 1; wr_data = 32'h0BADF00D; tick(); tick();
    wr_valid = 0; tick();
    #2 reset = 0; #1;
    chk("arst_mem_en", mem_en, 0);     chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0); chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_rd_grant", rd_grant, 0); chk("arst_rd_valid", rd_data_valid, 0);
    chk("arst_rd_data", rd_data, 0);   chk("arst_frame_ready", frame_ready, 0);
    rd_req = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset(); reset = 1;
    repeat (5) tick();
    chk("arst_idle_en", mem_en, 0); chk("arst_idle_valid", rd_data_valid, 0);
    $display("async reset: outputs cleared mid-transaction");

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!(rd_req && !last_grant)) begin
        rd_req = 1'($urandom_range(0, 1)); rd_addr_x = 10'($urandom); rd_addr_y = 10'($urandom);
      end
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_addr_x = 10'($urandom); wr_addr_y = 10'($urandom); wr_data = $urandom;
      if ($urandom_range(0, 63) == 0) wr_frame_done = ~wr_frame_done;
      tick();
    end
    $display("random: 3000 cycles of mixed traffic");

    // Full frame with periodic display reads.
    do_reset();
    idx = 0; cyc = 0;
    while (idx < 38400 && cyc < 60000) begin
      if (!(rd_req && !last_grant)) begin
        rd_req = (cyc % 4 == 0);
        rd_addr_x = 10'($urandom_range(0, 639)); rd_addr_y = 10'($urandom_range(0, 479));
      end
      wr_valid = (cyc % 4 != 0);
      wr_addr_x = 10'((idx % 80) * 8); wr_addr_y = 10'(idx / 80); wr_data = $urandom;
      tick();
      if (wr_valid) idx++;
      cyc++;
    end
    chk("frame_all_written", idx, 38400);
    wr_valid = 0; rd_req = 0; wr_frame_done = 1;
    for (int i = 0; i < 40 && !frame_ready; i++) tick();
    chk("frame_ready_set", frame_ready, 1);
    chk("frame_no_overflow", fifo_overflow, 0);
    bad = 0;
    for (int a = 0; a < 38400; a++) if (ram[a] !== img[a]) bad++;
    chk("frame_ram_image", bad, 0);
    wr_valid = 1; wr_addr_x = '0; wr_addr_y = '0; wr_data = 32'h5EED0001; tick();
    wr_valid = 0;
    chk("frame_ready_clear", frame_ready, 0);
    repeat (4) tick();
    $display("full frame: %0d writes in %0d cycles, %0d RAM words differ", idx, cyc, bad);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port framebuffer RAM between two clients: the UART-fed framebuffer writer (write-only, fire-and-forget pulses) and the VGA display fetch (read, latency-sensitive).
- Buffers writer pulses in a small FIFO so none are lost while the display holds the port.
- Converts (x, y) pixel coordinates to linear word addresses.
- Reports when a received frame is fully committed to RAM.

Parameters:
- H_RES, 640, pixels per line.
- PIX_PER_WORD, 8, 4-bit pixels packed per 32-bit word (power of 2).
- ADDR_W, 16, RAM word-address width (38400 words used).
- FIFO_DEPTH, 4, write FIFO entries (power of 2).
- STARVE_LIMIT, 8, consecutive cycles a full FIFO may be denied before a write is forced.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_addr_x  in  10  writer pixel x
- wr_addr_y  in  10  writer pixel y
- wr_data  in  32  writer packed pixel word
- wr_valid  in  1  one-cycle write pulse from writer
- wr_frame_done  in  1  writer frame-complete level
- rd_req  in  1  display read request; held with its address until rd_grant
- rd_addr_x  in  10  display pixel x
- rd_addr_y  in  10  display pixel y
- rd_grant  out  1  read accepted this cycle
- rd_data  out  32  read word (passthrough of mem_rdata)
- rd_data_valid  out  1  rd_data valid
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, 1-cycle latency after mem_en with mem_we=0
- fifo_overflow  out  1  sticky: a write pulse was dropped
- frame_ready  out  1  frame fully committed to RAM

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, starve counter 0, frame FSM in RECEIVING.
- Address mapping: addr = y*(H_RES/PIX_PER_WORD) + (x >> log2(PIX_PER_WORD)), truncated to ADDR_W. Defaults give y*80 + x/8.
- Write FIFO push: entry {addr, data} pushed on wr_valid.
  - Full with no pop in the same cycle: pulse dropped, fifo_overflow set until reset.
  - Full with a pop in the same cycle: push accepted.
- Per-cycle arbitration (combinational decision, all mem_* outputs registered):
  - Default: rd_req=1 wins and the read is issued.
  - Forced write: FIFO full and starve counter == STARVE_LIMIT. The write wins, rd_grant stays 0, the counter clears, and rd_req must be held.
  - Otherwise, FIFO non-empty: pop the head and issue a write.
  - Otherwise: mem_en=0.
- Starve counter: increments each cycle the FIFO is full and a read wins; clears when a write is issued or the FIFO is not full.
- Read timing, rd_req sampled high in cycle N and granted:
  - rd_grant=1 in cycle N (combinational).
  - mem_en=1, mem_we=0, mem_addr valid in N+1.
  - rd_data_valid=1 and rd_data=mem_rdata in N+2.
  - Back-to-back grants give one word per cycle.
- Write timing: popped in cycle N; mem_en=1, mem_we=1, mem_addr, mem_wdata in N+1. Writes commit in FIFO order.
- Frame FSM:
  - RECEIVING -> DRAINING on wr_frame_done rising edge.
  - DRAINING -> READY when the FIFO is empty and no write is pending in the output register.
  - READY holds frame_ready=1; READY -> RECEIVING on the next wr_valid, with frame_ready=0 the following cycle.
  - wr_valid arriving in DRAINING is pushed normally; the FSM stays in DRAINING.
- Reset mid-operation: FIFO contents discarded, in-flight read produces no rd_data_valid.

Test Plan:
- Single write, no reads: wr_valid with x=16, y=2, data=32'hDEADBEEF -> two cycles later mem_we=1, mem_addr=162, mem_wdata=32'hDEADBEEF.
- Single read: rd_req with x=632, y=479 -> rd_grant same cycle, mem_addr=38399 with mem_we=0 next cycle, rd_data_valid with RAM-model data the cycle after.
- Contention: rd_req held continuously while 4 writes pulse -> reads granted every cycle until the FIFO is full for 8 denied cycles. Then one cycle with rd_grant=0 and a write issued, then reads resume; all 4 writes land in order.
- Overflow: 5 wr_valid pulses on consecutive cycles under continuous rd_req -> 5th pulse dropped, fifo_overflow=1 and stays 1 until reset.
- Full frame: 38400 random writes (x step 8, y 0..479) interleaved with periodic display reads, then wr_frame_done -> frame_ready=1 after the FIFO drains. RAM model matches scoreboard; frame_ready clears after the first write of the next frame.
- Async reset during a read and with a non-empty FIFO -> all outputs 0 immediately, no further mem_en or rd_data_valid until new requests arrive.
